// File: rtl/fc_out_writeback_pkg.sv
// Shared FC output-stage constants and the writeback state encoding.
// Default parameter values for the output stage live here so every module agrees.
package fc_out_writeback_pkg;

  localparam int FC_OUTNEURON_DEF          = 16;
  localparam int FC_PO_DEF                 = 2;
  localparam int FC_ACCUM_DATA_WIDTH_DEF   = 40;
  localparam int FC_DATA_WIDTH_DEF         = 16;
  localparam int FC_OUTNEURON_ADDR_WIDTH_DEF = 4;
  localparam int FC_FRAC_SHIFT_DEF         = 8;
  localparam int FC_MULT_LATENCY_DEF       = 3;
  localparam int FC_RELU_EN_DEF            = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/fc_out_writeback_requant.sv
// fc_requant: round-half-up arithmetic shift, saturation to the output width, optional ReLU.
// Purely combinational; one accumulator word in, one output word out.
module fc_requant
  import fc_out_writeback_pkg::*;
#(
  parameter int ACC_W      = FC_ACCUM_DATA_WIDTH_DEF,
  parameter int DATA_W     = FC_DATA_WIDTH_DEF,
  parameter int FRAC_SHIFT = FC_FRAC_SHIFT_DEF,
  parameter int RELU_EN    = FC_RELU_EN_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_word,
  output logic signed [DATA_W-1:0] q_word
);

  // One guard bit above the accumulator so the rounding add cannot wrap
  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1) << (FRAC_SHIFT-1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W:0]  sum;
  logic signed [ACC_W:0]  shifted;
  logic signed [DATA_W-1:0] sat;

  always_comb begin
    sum     = {acc_word[ACC_W-1], acc_word} + RND;
    shifted = sum >>> FRAC_SHIFT;
    if (shifted > MAXV)
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < MINV)
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat = shifted[DATA_W-1:0];
    if ((RELU_EN != 0) && sat[DATA_W-1])
      q_word = '0;
    else
      q_word = sat;
  end

endmodule

// File: rtl/fc_out_writeback.sv
// FC output writeback: captures PO accumulators per window, requantises and serialises them into the output RAM.
//   state | meaning
//   IDLE  | waiting for enable
//   ARMED | discarding the pipeline-fill capture strobe
//   RUN   | capturing windows and writing words
//   DONE  | all OUTNEURON words written; held until reset
module fc_out_writeback
  import fc_out_writeback_pkg::*;
#(
  parameter int OUTNEURON               = FC_OUTNEURON_DEF,
  parameter int PO                      = FC_PO_DEF,
  parameter int ACCUM_DATA_WIDTH_FC     = FC_ACCUM_DATA_WIDTH_DEF,
  parameter int DATA_WIDTH_FC           = FC_DATA_WIDTH_DEF,
  parameter int FC_OUTNEURON_ADDR_WIDTH = FC_OUTNEURON_ADDR_WIDTH_DEF,
  parameter int FRAC_SHIFT              = FC_FRAC_SHIFT_DEF,
  parameter int MULT_LATENCY            = FC_MULT_LATENCY_DEF,
  parameter int RELU_EN                 = FC_RELU_EN_DEF
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  accum_sload,
  input  logic [ACCUM_DATA_WIDTH_FC*PO-1:0]     accum_result_all,
  output logic                                  out_neuron_wren,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]    out_neuron_addr,
  output logic [DATA_WIDTH_FC-1:0]              out_neuron_data,
  output logic                                  busy,
  output logic                                  overrun,
  output logic                                  done
);

  localparam int ACC_W  = ACCUM_DATA_WIDTH_FC;
  localparam int ADDR_W = FC_OUTNEURON_ADDR_WIDTH;
  localparam int IDX_W  = (PO > 1) ? $clog2(PO) : 1;

  wb_state_e state, state_nxt;

  logic [MULT_LATENCY-1:0] sload_dly;
  logic                    cap_strb;
  logic signed [ACC_W-1:0] cap_buf [PO];
  logic [IDX_W-1:0]        idx;
  logic [ADDR_W-1:0]       out_addr;
  logic signed [DATA_WIDTH_FC-1:0] q_word;

  logic last_wr, final_seen, do_write, do_capture, set_ovr;

  assign cap_strb = sload_dly[MULT_LATENCY-1];

  fc_requant #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_WIDTH_FC),
    .FRAC_SHIFT (FRAC_SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_requant (
    .acc_word (cap_buf[idx]),
    .q_word   (q_word)
  );

  always_comb begin
    state_nxt  = state;
    do_write   = 1'b0;
    do_capture = 1'b0;
    set_ovr    = 1'b0;
    last_wr    = busy && (idx == IDX_W'(PO-1));
    final_seen = out_neuron_wren && (out_neuron_addr == ADDR_W'(OUTNEURON-1));
    case (state)
      ST_IDLE:  if (enable) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!enable)
          state_nxt = ST_IDLE;
        else if (cap_strb)
          state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (final_seen) begin
          state_nxt = ST_DONE;
        end else begin
          do_write = busy;
          // A strobe landing on the last word of a window is a clean hand-off, not an overrun
          if (cap_strb && enable) begin
            if (!busy || last_wr)
              do_capture = 1'b1;
            else
              set_ovr = 1'b1;
          end
          if (!enable && !busy)
            state_nxt = ST_IDLE;
        end
      end
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= ST_IDLE;
      sload_dly       <= '0;
      idx             <= '0;
      out_addr        <= '0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      done            <= 1'b0;
      out_neuron_wren <= 1'b0;
      out_neuron_addr <= '0;
      out_neuron_data <= '0;
      for (int p = 0; p < PO; p++) cap_buf[p] <= '0;
    end else begin
      state           <= state_nxt;
      sload_dly       <= (sload_dly << 1) | MULT_LATENCY'(accum_sload);
      out_neuron_wren <= do_write;
      if (do_write) begin
        out_neuron_addr <= out_addr;
        out_neuron_data <= q_word;
        out_addr        <= out_addr + ADDR_W'(1);
        idx             <= idx + IDX_W'(1);
        if (last_wr) busy <= 1'b0;
      end
      if (do_capture) begin
        for (int p = 0; p < PO; p++)
          cap_buf[p] <= accum_result_all[p*ACC_W +: ACC_W];
        idx  <= '0;
        busy <= 1'b1;
      end
      if (set_ovr) overrun <= 1'b1;
      if (state_nxt == ST_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_out_writeback.sv
// Bench for fc_out_writeback: queue-based behavioural model checked every cycle, plus literal expectations per scenario.
module tb_fc_out_writeback;

  localparam int N = 16, PO = 2, ACC = 40, DW = 16, AW = 4, FS = 8, L = 3, RELU = 1;

  logic clock = 1'b0, reset = 1'b0, enable = 1'b0, accum_sload = 1'b0;
  logic [ACC*PO-1:0] acc_all = '0;
  logic          wren;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          busy, overrun, done;

  fc_out_writeback #(
    .OUTNEURON(N), .PO(PO), .ACCUM_DATA_WIDTH_FC(ACC), .DATA_WIDTH_FC(DW),
    .FC_OUTNEURON_ADDR_WIDTH(AW), .FRAC_SHIFT(FS), .MULT_LATENCY(L), .RELU_EN(RELU)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .accum_sload(accum_sload),
    .accum_result_all(acc_all), .out_neuron_wren(wren), .out_neuron_addr(addr),
    .out_neuron_data(data), .busy(busy), .overrun(overrun), .done(done)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mq(input longint x);
    longint y;
    y = (x + (64'sd1 <<< (FS-1))) >>> FS;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    if (RELU != 0 && y < 0) y = 0;
    return y[DW-1:0];
  endfunction

  // Behavioural model: mode 0 idle, 1 armed, 2 run, 3 done; pend holds words still to be written
  int hq[$];
  logic [DW-1:0] pend[$];
  int mode = 0, maddr = 0, np = 0;
  bit cap, fin, mvalid = 0;
  logic e_wren = 0, e_busy = 0, e_ovr = 0, e_done = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      mvalid = 1; hq.delete(); pend.delete(); mode = 0; maddr = 0;
      e_wren = 0; e_busy = 0; e_ovr = 0; e_done = 0; e_addr = '0; e_data = '0;
    end else begin
      cap = 0;
      if (hq.size() == L) begin cap = (hq[0] != 0); void'(hq.pop_front()); end
      hq.push_back(int'(accum_sload));
      fin = e_wren && (e_addr == AW'(N-1));
      np  = pend.size();
      e_wren = 0;
      case (mode)
        0: if (enable) mode = 1;
        1: if (!enable) mode = 0; else if (cap) mode = 2;
        2: begin
          if (fin) begin
            mode = 3; e_done = 1; pend.delete();
          end else begin
            if (np > 0) begin
              e_wren = 1; e_addr = maddr[AW-1:0]; e_data = pend.pop_front(); maddr++;
            end
            if (cap && enable) begin
              if (np <= 1)
                for (int p = 0; p < PO; p++)
                  pend.push_back(mq(longint'($signed(acc_all[p*ACC +: ACC]))));
              else
                e_ovr = 1;
            end
            if (!enable && np == 0) mode = 0;
          end
        end
        default: ;
      endcase
      e_busy = (pend.size() > 0);
    end
  end

  int log_addr[$], log_data[$], log_cyc[$];
  int done_cyc = -1;

  always @(negedge clock) begin
    if (mvalid) begin
      chk("wren", wren, e_wren);
      chk("busy", busy, e_busy);
      chk("overrun", overrun, e_ovr);
      chk("done", done, e_done);
      if (e_wren) begin
        chk("addr", addr, e_addr);
        chk("data", data, e_data);
      end
      if (wren === 1'b1) begin
        log_addr.push_back(int'(addr)); log_data.push_back(int'(data)); log_cyc.push_back(cyc);
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse();
    accum_sload = 1'b1; tick(1); accum_sload = 1'b0;
  endtask

  task automatic set_acc(input longint a0, input longint a1);
    acc_all = {a1[ACC-1:0], a0[ACC-1:0]};
  endtask

  task automatic chk_log(input string nm, input int i, input int ea, input int ed);
    if (i >= log_addr.size()) begin
      n_cmp++; n_err++;
      $display("FAIL %s: write %0d missing, expected addr %0d data %0h", nm, i, ea, ed);
    end else begin
      chk({nm, "_addr"}, log_addr[i], ea);
      chk({nm, "_data"}, log_data[i], ed);
    end
  endtask

  int base, found;

  initial begin
    tick(3);
    chk("rst_wren", wren, 0); chk("rst_addr", addr, 0); chk("rst_data", data, 0);
    chk("rst_busy", busy, 0); chk("rst_ovr", overrun, 0); chk("rst_done", done, 0);
    reset = 1'b1; enable = 1'b1; tick(2);

    // Basic flow: first pulse is pipeline fill
    pulse(); tick(10);
    chk("fill_no_write", log_addr.size(), 0);
    set_acc(64'h280, 64'h180); pulse(); tick(10);
    chk_log("basic0", 0, 0, 3); chk_log("basic1", 1, 1, 2);

    set_acc(64'sd1 <<< 30, -(64'sd1 <<< 30)); pulse(); tick(10);
    chk_log("sat_pos", 2, 2, 16'h7FFF); chk_log("relu_neg", 3, 3, 0);

    set_acc(64'h7F, 64'h80); pulse(); tick(10);
    chk_log("round_lo", 4, 4, 0); chk_log("round_hi", 5, 5, 1);

    // Back-to-back: pulses PO cycles apart
    set_acc(64'h1000, 64'h2000); pulse(); tick(1); pulse(); tick(12);
    chk_log("b2b0", 6, 6, 16); chk_log("b2b3", 9, 9, 32);
    if (log_cyc.size() >= 10) chk("b2b_span", log_cyc[9] - log_cyc[6], 3);
    chk("b2b_no_ovr", overrun, 0);

    // Overrun: second pulse one cycle later, with different data by then
    set_acc(64'h300, 64'h400); accum_sload = 1'b1; tick(2); accum_sload = 1'b0; tick(2);
    set_acc(64'h900, 64'h900); tick(10);
    chk("ovr_flag", overrun, 1); chk("ovr_count", log_addr.size(), 12);
    chk_log("ovr0", 10, 10, 3); chk_log("ovr1", 11, 11, 4);

    // enable low: strobes ignored, address preserved across re-arm
    enable = 1'b0; tick(3); pulse(); tick(10);
    chk("dis_no_write", log_addr.size(), 12);
    enable = 1'b1; tick(2); pulse(); tick(10);
    set_acc(64'h500, 64'h600); pulse(); tick(10);
    chk_log("rearm0", 12, 12, 5); chk_log("rearm1", 13, 13, 6);

    // Reset mid-write
    reset = 1'b0; tick(2); reset = 1'b1; tick(2);
    pulse(); tick(8); set_acc(64'h900, 64'hA00); pulse();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1); if (wren === 1'b1) found = 1;
    end
    chk("rst_first_wr_seen", found, 1);
    tick(1); reset = 1'b0; tick(1);
    chk("mid_rst_wren", wren, 0); chk("mid_rst_addr", addr, 0); chk("mid_rst_data", data, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_ovr", overrun, 0); chk("mid_rst_done", done, 0);
    reset = 1'b1; tick(2);

    // Completion: 9 pulses, 32 cycles apart, 16 writes with data == addr
    base = log_addr.size();
    for (int p = 0; p < 9; p++) begin
      if (p > 0) set_acc(longint'(2*(p-1)) <<< 8, longint'(2*(p-1)+1) <<< 8);
      pulse(); tick(31);
    end
    tick(10);
    chk("cmpl_count", log_addr.size() - base, 16);
    for (int i = 0; i < 16; i++) chk_log("cmpl", base + i, i, i);
    if (log_cyc.size() >= base + 16) chk("done_timing", done_cyc, log_cyc[base+15] + 1);
    chk("done_held", done, 1);
    pulse(); tick(20);
    chk("post_done_no_write", log_addr.size() - base, 16);
    chk("done_still", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
